// File: rtl/polygon_pkg.sv
// polygon_pkg: shared coordinate/polygon types and scheduler FSM states
// Defaults here seed the module parameters; polygon_t describes one table entry
// at the default geometry.
package polygon_pkg;
  localparam int DEF_WORLD_BITS = 18;
  localparam int DEF_MAX_NUM_VERTICES = 8;
  localparam int DEF_NP_BITS = $clog2(DEF_MAX_NUM_VERTICES + 1);
  typedef logic signed [DEF_WORLD_BITS-1:0] coord_t;
  typedef struct packed {
    coord_t [DEF_MAX_NUM_VERTICES-1:0] xs;
    coord_t [DEF_MAX_NUM_VERTICES-1:0] ys;
    logic [DEF_NP_BITS-1:0] num_points;
  } polygon_t;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/polygon_table.sv
// polygon_table: polygon vertex register file, one write port, combinational read
// Ports: clk/rst (async, active-high, clears every entry), wr_* write one vertex
// slot and the entry's vertex count, rd_idx selects the entry shown on rd_*.
module polygon_table #(
  parameter int MAX_NUM_VERTICES = 8,
  parameter int WORLD_BITS = 18,
  parameter int NUM_POLYGONS = 4,
  localparam int PW = NUM_POLYGONS > 1 ? $clog2(NUM_POLYGONS) : 1,
  localparam int VW = MAX_NUM_VERTICES > 1 ? $clog2(MAX_NUM_VERTICES) : 1,
  localparam int NW = $clog2(MAX_NUM_VERTICES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [PW-1:0] wr_poly,
  input  logic [VW-1:0] wr_vertex,
  input  logic signed [WORLD_BITS-1:0] wr_x,
  input  logic signed [WORLD_BITS-1:0] wr_y,
  input  logic [NW-1:0] wr_num_points,
  input  logic [PW-1:0] rd_idx,
  output logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0] rd_xs,
  output logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0] rd_ys,
  output logic [NW-1:0] rd_num_points
);
  logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0] xs [NUM_POLYGONS];
  logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0] ys [NUM_POLYGONS];
  logic [NW-1:0] np [NUM_POLYGONS];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_POLYGONS; i++) begin
        xs[i] <= '0;
        ys[i] <= '0;
        np[i] <= '0;
      end
    end else if (wr_en) begin
      xs[wr_poly][wr_vertex] <= wr_x;
      ys[wr_poly][wr_vertex] <= wr_y;
      np[wr_poly] <= wr_num_points;
    end
  end
  assign rd_xs = xs[rd_idx];
  assign rd_ys = ys[rd_idx];
  assign rd_num_points = np[rd_idx];
endmodule

// File: rtl/polygon_hit_scheduler.sv
// polygon_hit_scheduler: streams every stored polygon through one in_polygon datapath per query
// Ports: clk_in/rst_in (async, active-high); wr_* table write (IDLE only);
// req_* query handshake; ip_* datapath drive and ip_result_in return;
// res_* result handshake with hit mask, any-hit and lowest hit index; busy_out.
module polygon_hit_scheduler
  import polygon_pkg::*;
#(
  parameter int MAX_NUM_VERTICES = DEF_MAX_NUM_VERTICES,
  parameter int WORLD_BITS = DEF_WORLD_BITS,
  parameter int NUM_POLYGONS = 4,
  parameter int IP_LATENCY = 2,
  localparam int PW = NUM_POLYGONS > 1 ? $clog2(NUM_POLYGONS) : 1,
  localparam int VW = MAX_NUM_VERTICES > 1 ? $clog2(MAX_NUM_VERTICES) : 1,
  localparam int NW = $clog2(MAX_NUM_VERTICES + 1)
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic wr_en_in,
  input  logic [PW-1:0] wr_poly_in,
  input  logic [VW-1:0] wr_vertex_in,
  input  logic signed [WORLD_BITS-1:0] wr_x_in,
  input  logic signed [WORLD_BITS-1:0] wr_y_in,
  input  logic [NW-1:0] wr_num_points_in,
  input  logic req_valid_in,
  output logic req_ready_out,
  input  logic signed [WORLD_BITS-1:0] req_x_in,
  input  logic signed [WORLD_BITS-1:0] req_y_in,
  output logic signed [WORLD_BITS-1:0] ip_x_out,
  output logic signed [WORLD_BITS-1:0] ip_y_out,
  output logic signed [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0] ip_xs_out,
  output logic signed [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0] ip_ys_out,
  output logic [NW-1:0] ip_num_points_out,
  input  logic ip_result_in,
  output logic res_valid_out,
  input  logic res_ready_in,
  output logic [NUM_POLYGONS-1:0] res_mask_out,
  output logic res_hit_out,
  output logic [PW-1:0] res_index_out,
  output logic busy_out
);
  localparam int LD = IP_LATENCY > 0 ? IP_LATENCY : 1;
  state_t state;
  logic signed [WORLD_BITS-1:0] qx, qy, hx, hy;
  logic [MAX_NUM_VERTICES-1:0][WORLD_BITS-1:0] rxs, rys, hxs, hys;
  logic [NW-1:0] rn, hn;
  logic [PW-1:0] idx, etag;
  logic [NUM_POLYGONS-1:0] mask;
  logic [LD-1:0] pv, pok;
  logic [PW-1:0] ptag [LD];
  logic issue, ok, ev, eok;

  polygon_table #(
    .MAX_NUM_VERTICES(MAX_NUM_VERTICES),
    .WORLD_BITS(WORLD_BITS),
    .NUM_POLYGONS(NUM_POLYGONS)
  ) u_table (
    .clk(clk_in),
    .rst(rst_in),
    .wr_en(wr_en_in && state == IDLE),
    .wr_poly(wr_poly_in),
    .wr_vertex(wr_vertex_in),
    .wr_x(wr_x_in),
    .wr_y(wr_y_in),
    .wr_num_points(wr_num_points_in),
    .rd_idx(idx),
    .rd_xs(rxs),
    .rd_ys(rys),
    .rd_num_points(rn)
  );

  assign issue = state == ISSUE;
  // degenerate entries are still issued but can never report a hit
  assign ok = rn >= NW'(3);
  // with zero datapath latency the result belongs to the entry driven this cycle
  assign ev = IP_LATENCY == 0 ? issue : pv[LD-1];
  assign eok = IP_LATENCY == 0 ? ok : pok[LD-1];
  assign etag = IP_LATENCY == 0 ? idx : ptag[LD-1];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      qx <= '0;
      qy <= '0;
      hx <= '0;
      hy <= '0;
      hxs <= '0;
      hys <= '0;
      hn <= '0;
      idx <= '0;
      mask <= '0;
      pv <= '0;
      pok <= '0;
      for (int i = 0; i < LD; i++) ptag[i] <= '0;
    end else begin
      pv <= LD'({pv, issue});
      pok <= LD'({pok, ok});
      ptag[0] <= idx;
      for (int i = 1; i < LD; i++) ptag[i] <= ptag[i-1];
      if (ev) mask[etag] <= ip_result_in & eok;
      if (issue) begin
        hx <= qx;
        hy <= qy;
        hxs <= rxs;
        hys <= rys;
        hn <= rn;
        idx <= idx + 1'b1;
      end
      case (state)
        IDLE: if (req_valid_in) begin
          state <= ISSUE;
          qx <= req_x_in;
          qy <= req_y_in;
          mask <= '0;
          idx <= '0;
        end
        ISSUE: if (idx == PW'(NUM_POLYGONS - 1)) state <= IP_LATENCY == 0 ? DONE : DRAIN;
        DRAIN: if (ev && etag == PW'(NUM_POLYGONS - 1)) state <= DONE;
        default: if (res_ready_in) state <= IDLE;
      endcase
    end
  end

  // outside ISSUE the datapath inputs hold the last entry driven
  assign ip_x_out = issue ? qx : hx;
  assign ip_y_out = issue ? qy : hy;
  assign ip_xs_out = issue ? rxs : hxs;
  assign ip_ys_out = issue ? rys : hys;
  assign ip_num_points_out = issue ? rn : hn;

  always_comb begin
    res_index_out = '0;
    for (int k = NUM_POLYGONS - 1; k >= 0; k--) if (mask[k]) res_index_out = PW'(k);
  end

  assign req_ready_out = state == IDLE;
  assign busy_out = state != IDLE;
  assign res_valid_out = state == DONE;
  assign res_mask_out = mask;
  assign res_hit_out = |mask;
endmodule
